spi_cmd_engine: RTL and testbench

SPI_CMD_ENGINE -- requirements
Module: spi_cmd_engine

---
 rtl/spi_cmd_pkg.sv | 38 +++
 rtl/sprite_fifo.sv | 71 +++++++
 rtl/spi_cmd_engine.sv | 252 +++++++++++++++++++++++++
 tb/tb_spi_cmd_engine.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared types for the SPI command engine: command codes, FSM states, draw entry and status layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_cmd_pkg;

  localparam logic [7:0] CMD_DRAW   = 8'h01;
  localparam logic [7:0] CMD_LOAD   = 8'h02;
  localparam logic [7:0] CMD_FLUSH  = 8'h03;
  localparam logic [7:0] CMD_STATUS = 8'h04;

  // Payload bytes following a DRAW command: id, x_hi, x_lo, y_hi, y_lo, scale
  localparam int DRAW_BYTES = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DRAW,
    ST_LOAD_ID,
    ST_LOAD_DATA,
    ST_STATUS,
    ST_DISCARD
  } state_t;

  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  scale;
  } draw_entry_t;

  // Byte returned on MISO after a STATUS command, MSB first
  typedef struct packed {
    logic       empty;
    logic       full;
    logic [5:0] ovf;
  } status_t;

endpackage

// File: rtl/sprite_fifo.sv
// First-word-fall-through draw queue with flush; head is zero whenever the queue is empty.
// Latency: a push is visible at the head on the following cycle; flush empties on the next cycle.
// Backpressure: none; a push while full without a pop is dropped and flagged on o_drop.
module sprite_fifo
  import spi_cmd_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter type T     = draw_entry_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_flush,
  input  logic i_push,
  input  T     i_dat,
  input  logic i_pop,
  output T     o_dat,
  output logic o_empty,
  output logic o_full,
  output logic o_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  // A pop frees the head slot in the same cycle, so a full queue still accepts a push
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_drop    = i_push & o_full & ~i_pop & ~i_flush;

  // Storage write; contents are don't-care until pointed at by a valid count
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_dat;
  end

  // Pointer and occupancy tracking; flush wins over any same-cycle push or pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head presented combinationally, forced to zero when nothing is queued
  always_comb begin
    o_dat = '0;
    if (!o_empty) o_dat = r_mem[r_rd_ptr];
  end

endmodule

// File: rtl/spi_cmd_engine.sv
// SPI mode-0 slave decoding DRAW/LOAD/FLUSH/STATUS commands into a draw queue and sprite storage writes.
// Latency: sync depth + 2 cycles from sck rise to the byte's action (enqueue, write strobe, status load).
// Backpressure: none toward SPI; draws arriving at a full queue are dropped and counted in overflow_count.
module spi_cmd_engine
  import spi_cmd_pkg::*;
#(
  parameter int QUEUE_DEPTH   = 16,
  parameter int SPRITE_NUM    = 64,
  parameter int SPRITE_ADDR_W = 12,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                          sys_clock,
  input  logic                          sys_reset_n,
  input  logic                          spi_sck,
  input  logic                          spi_cs,
  input  logic                          spi_mosi,
  output logic                          spi_miso,
  output logic [$clog2(SPRITE_NUM)-1:0] sprite_select,
  output logic                          sprite_w_en,
  output logic [SPRITE_ADDR_W-1:0]      sprite_w_addr,
  output logic [7:0]                    sprite_w_data,
  input  logic                          dequeue,
  output logic                          is_empty,
  output logic                          is_full,
  output logic [7:0]                    sprite_id,
  output logic [15:0]                   sprite_x,
  output logic [15:0]                   sprite_y,
  output logic [7:0]                    sprite_scale,
  output logic [7:0]                    overflow_count
);

  localparam int SEL_W = $clog2(SPRITE_NUM);

  // {sck, cs, mosi} per synchroniser stage
  logic [2:0]               r_sync [SYNC_STAGES];
  logic                     r_sck_d;
  logic                     r_cs_d;
  logic                     w_sck_s, w_cs_s, w_mosi_s;
  logic                     w_sck_rise, w_sck_fall, w_cs_fall;

  logic [2:0]               r_bit_cnt;
  logic [7:0]               r_shift;
  logic                     r_byte_vld;

  state_t                   r_state, w_state_nxt;
  logic                     w_enq, w_flush, w_status_ld, w_wr, w_sel_ld;

  logic [2:0]               r_draw_idx;
  logic [39:0]              r_draw_sr;
  logic [SEL_W-1:0]         r_sel;
  logic [SPRITE_ADDR_W-1:0] r_addr;
  logic                     r_w_en;
  logic [SPRITE_ADDR_W-1:0] r_w_addr;
  logic [7:0]               r_w_data;
  logic [7:0]               r_ovf;
  logic                     r_miso;
  logic [6:0]               r_miso_sr;

  draw_entry_t              w_entry, w_head;
  status_t                  w_status;
  logic                     w_empty, w_full, w_drop;

  assign w_sck_s    = r_sync[SYNC_STAGES-1][2];
  assign w_cs_s     = r_sync[SYNC_STAGES-1][1];
  assign w_mosi_s   = r_sync[SYNC_STAGES-1][0];
  assign w_sck_rise = w_sck_s & ~r_sck_d;
  assign w_sck_fall = ~w_sck_s & r_sck_d;
  assign w_cs_fall  = ~w_cs_s & r_cs_d;

  // Bring the three SPI pins into the system clock domain and keep one-cycle-old copies for edge detection
  always_ff @(posedge sys_clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_sck_d <= 1'b0;
      r_cs_d  <= 1'b0;
    end else begin
      r_sync[0] <= {spi_sck, spi_cs, spi_mosi};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_sck_d <= w_sck_s;
      r_cs_d  <= w_cs_s;
    end
  end

  // MSB-first shifter; the byte strobe follows the 8th rise and cs high discards any partial byte
  always_ff @(posedge sys_clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_byte_vld <= 1'b0;
    end else if (w_cs_s) begin
      r_bit_cnt  <= '0;
      r_byte_vld <= 1'b0;
    end else begin
      r_byte_vld <= 1'b0;
      if (w_sck_rise) begin
        r_shift   <= {r_shift[6:0], w_mosi_s};
        r_bit_cnt <= r_bit_cnt + 1'b1;
        if (r_bit_cnt == 3'd7) r_byte_vld <= 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge sys_clock or negedge sys_reset_n) begin
    if (!sys_reset_n) r_state <= ST_IDLE;
    else              r_state <= w_state_nxt;
  end

  // Command decode: next state plus single-cycle action strobes for the datapath
  always_comb begin
    w_state_nxt = r_state;
    w_enq       = 1'b0;
    w_flush     = 1'b0;
    w_status_ld = 1'b0;
    w_wr        = 1'b0;
    w_sel_ld    = 1'b0;
    if (w_cs_s) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_cs_fall) w_state_nxt = ST_CMD;
        ST_CMD: begin
          if (r_byte_vld) begin
            case (r_shift)
              CMD_DRAW:   w_state_nxt = ST_DRAW;
              CMD_LOAD:   w_state_nxt = ST_LOAD_ID;
              CMD_FLUSH:  w_flush     = 1'b1;
              CMD_STATUS: begin
                w_status_ld = 1'b1;
                w_state_nxt = ST_STATUS;
              end
              default:    w_state_nxt = ST_DISCARD;
            endcase
          end
        end
        ST_DRAW: begin
          if (r_byte_vld && r_draw_idx == 3'(DRAW_BYTES - 1)) begin
            w_enq       = 1'b1;
            w_state_nxt = ST_CMD;
          end
        end
        ST_LOAD_ID: begin
          if (r_byte_vld) begin
            if ({24'd0, r_shift} < SPRITE_NUM) begin
              w_sel_ld    = 1'b1;
              w_state_nxt = ST_LOAD_DATA;
            end else begin
              w_state_nxt = ST_DISCARD;
            end
          end
        end
        ST_LOAD_DATA: if (r_byte_vld) w_wr = 1'b1;
        ST_STATUS:    if (r_byte_vld) w_state_nxt = ST_CMD;
        ST_DISCARD:   w_state_nxt = ST_DISCARD;
        default:      w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // DRAW payload collection; the index restarts whenever the FSM leaves DRAW
  always_ff @(posedge sys_clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_draw_idx <= '0;
      r_draw_sr  <= '0;
    end else if (r_state != ST_DRAW) begin
      r_draw_idx <= '0;
    end else if (r_byte_vld) begin
      r_draw_idx <= r_draw_idx + 1'b1;
      r_draw_sr  <= {r_draw_sr[31:0], r_shift};
    end
  end

  // Sprite storage port: slot select, auto-incrementing byte address and one-cycle write strobe
  always_ff @(posedge sys_clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_sel    <= '0;
      r_addr   <= '0;
      r_w_en   <= 1'b0;
      r_w_addr <= '0;
      r_w_data <= '0;
    end else begin
      r_w_en <= w_wr;
      if (w_sel_ld) begin
        r_sel  <= r_shift[SEL_W-1:0];
        r_addr <= '0;
      end
      if (w_wr) begin
        r_w_addr <= r_addr;
        r_w_data <= r_shift;
        r_addr   <= r_addr + 1'b1;
      end
    end
  end

  // Dropped-draw counter, saturating
  always_ff @(posedge sys_clock or negedge sys_reset_n) begin
    if (!sys_reset_n)                r_ovf <= '0;
    else if (w_drop && r_ovf != 8'hFF) r_ovf <= r_ovf + 1'b1;
  end

  // Status readback: bit 7 is presented as soon as the command lands; the command byte's own
  // trailing fall (bit count 0) must not shift, so only falls inside the status byte advance MISO
  always_ff @(posedge sys_clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_miso    <= 1'b0;
      r_miso_sr <= '0;
    end else if (w_status_ld) begin
      r_miso    <= w_status.empty;
      r_miso_sr <= {w_status.full, w_status.ovf};
    end else if (r_state == ST_STATUS && !w_cs_s) begin
      if (w_sck_fall && r_bit_cnt != 3'd0) begin
        r_miso    <= r_miso_sr[6];
        r_miso_sr <= {r_miso_sr[5:0], 1'b0};
      end
    end else begin
      r_miso <= 1'b0;
    end
  end

  assign w_entry  = {r_draw_sr, r_shift};
  assign w_status = {w_empty, w_full, r_ovf[5:0]};

  sprite_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .T     (draw_entry_t)
  ) u_queue (
    .clk     (sys_clock),
    .rst_n   (sys_reset_n),
    .i_flush (w_flush),
    .i_push  (w_enq),
    .i_dat   (w_entry),
    .i_pop   (dequeue),
    .o_dat   (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_drop  (w_drop)
  );

  assign spi_miso       = r_miso;
  assign sprite_select  = r_sel;
  assign sprite_w_en    = r_w_en;
  assign sprite_w_addr  = r_w_addr;
  assign sprite_w_data  = r_w_data;
  assign is_empty       = w_empty;
  assign is_full        = w_full;
  assign sprite_id      = w_head.id;
  assign sprite_x       = w_head.x;
  assign sprite_y       = w_head.y;
  assign sprite_scale   = w_head.scale;
  assign overflow_count = r_ovf;

endmodule

// File: tb/tb_spi_cmd_engine.sv
// Randomised and directed bench for spi_cmd_engine against a byte-level command interpreter model.
// Latency: SPI clock runs at sys_clock/12; all sampling is on the falling system clock edge.
// Backpressure: dequeues are issued only between frames.
module tb_spi_cmd_engine;

  localparam int HALF  = 6;
  localparam int DEPTH = 16;

  logic        sys_clock = 1'b0;
  logic        sys_reset_n = 1'b0;
  logic        spi_sck = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        dequeue = 1'b0;
  logic        spi_miso;
  logic [5:0]  sprite_select;
  logic        sprite_w_en;
  logic [11:0] sprite_w_addr;
  logic [7:0]  sprite_w_data;
  logic        is_empty, is_full;
  logic [7:0]  sprite_id, sprite_scale, overflow_count;
  logic [15:0] sprite_x, sprite_y;

  always #5 sys_clock = ~sys_clock;

  spi_cmd_engine #(
    .QUEUE_DEPTH(DEPTH), .SPRITE_NUM(64), .SPRITE_ADDR_W(12), .SYNC_STAGES(2)
  ) dut (
    .sys_clock(sys_clock), .sys_reset_n(sys_reset_n),
    .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .sprite_select(sprite_select), .sprite_w_en(sprite_w_en),
    .sprite_w_addr(sprite_w_addr), .sprite_w_data(sprite_w_data),
    .dequeue(dequeue), .is_empty(is_empty), .is_full(is_full),
    .sprite_id(sprite_id), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .sprite_scale(sprite_scale), .overflow_count(overflow_count)
  );

  int          checks = 0;
  int          failures = 0;
  logic [47:0] mq[$];
  int          ovf_m = 0;
  logic [25:0] exp_wr[$];
  logic [25:0] act_wr[$];
  logic [7:0]  fb[$];
  logic [7:0]  exp_rx[$];
  logic [7:0]  act_rx[$];

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clock);
  endtask

  // Record every storage write strobe seen outside reset
  always @(negedge sys_clock) begin
    if (sys_reset_n && sprite_w_en) act_wr.push_back({sprite_select, sprite_w_addr, sprite_w_data});
  end

  task automatic spi_bits(input logic [7:0] b, input int nb, output logic [7:0] rx);
    rx = '0;
    for (int k = 0; k < nb; k++) begin
      spi_mosi = b[7-k];
      cyc(HALF);
      rx = {rx[6:0], spi_miso};
      spi_sck = 1'b1;
      cyc(HALF);
      spi_sck = 1'b0;
    end
  endtask

  function automatic void m_push(input logic [47:0] e);
    if (mq.size() < DEPTH) mq.push_back(e);
    else if (ovf_m < 255) ovf_m++;
  endfunction

  // Interpret one frame's complete bytes in order, updating queue, writes and expected MISO bytes
  function automatic void m_parse();
    int n;
    int i;
    logic [7:0] id;
    logic       e, f;
    n = fb.size();
    i = 0;
    exp_rx.delete();
    for (int k = 0; k < n; k++) exp_rx.push_back(8'h00);
    while (i < n) begin
      if (fb[i] == 8'h01) begin
        if (i + 6 < n) begin
          m_push({fb[i+1], fb[i+2], fb[i+3], fb[i+4], fb[i+5], fb[i+6]});
          i += 7;
        end else break;
      end else if (fb[i] == 8'h02) begin
        if (i + 1 < n) begin
          id = fb[i+1];
          if (id < 8'd64)
            for (int j = i + 2; j < n; j++) exp_wr.push_back({id[5:0], 12'(j - i - 2), fb[j]});
        end
        break;
      end else if (fb[i] == 8'h03) begin
        mq.delete();
        i += 1;
      end else if (fb[i] == 8'h04) begin
        e = (mq.size() == 0);
        f = (mq.size() == DEPTH);
        if (i + 1 < n) exp_rx[i+1] = {e, f, 6'(ovf_m)};
        i += 2;
      end else break;
    end
  endfunction

  task automatic check_state();
    logic [47:0] h;
    chk_val("is_empty", is_empty, mq.size() == 0);
    chk_val("is_full", is_full, mq.size() == DEPTH);
    chk_val("overflow_count", overflow_count, ovf_m);
    if (mq.size() > 0) begin
      h = mq[0];
      chk_val("head", {sprite_id, sprite_x, sprite_y, sprite_scale}, h);
    end
    chk_val("wr_count", act_wr.size(), exp_wr.size());
    if (act_wr.size() == exp_wr.size())
      for (int k = 0; k < exp_wr.size(); k++) chk_val("wr_event", act_wr[k], exp_wr[k]);
    act_wr.delete();
    exp_wr.delete();
  endtask

  task automatic run_frame(input int tail_bits, input logic [7:0] tail);
    logic [7:0] rx;
    m_parse();
    act_rx.delete();
    spi_cs = 1'b0;
    cyc(HALF);
    for (int k = 0; k < fb.size(); k++) begin
      spi_bits(fb[k], 8, rx);
      act_rx.push_back(rx);
      chk_val("miso_byte", rx, exp_rx[k]);
    end
    chk_val("empty_at_last_byte", is_empty, mq.size() == 0);
    if (tail_bits > 0) spi_bits(tail, tail_bits, rx);
    cyc(HALF);
    spi_cs = 1'b1;
    cyc(2 * HALF);
    check_state();
  endtask

  task automatic do_deq(input int n);
    for (int k = 0; k < n; k++) begin
      dequeue = 1'b1;
      cyc(1);
      dequeue = 1'b0;
      if (mq.size() > 0) mq.delete(0);
      cyc(1);
    end
    check_state();
  endtask

  task automatic rnd_draw();
    fb.push_back(8'h01);
    repeat (6) fb.push_back(8'($urandom));
  endtask

  task automatic rnd_frame(output int tail_bits);
    int  ncmd;
    int  r;
    bit  stop;
    fb.delete();
    stop = 1'b0;
    ncmd = int'($urandom_range(1, 3));
    for (int c = 0; c < ncmd && !stop; c++) begin
      r = int'($urandom_range(0, 11));
      if (r <= 4) rnd_draw();
      else if (r <= 6) begin
        fb.push_back(8'h04);
        fb.push_back(8'($urandom));
      end else if (r == 7) fb.push_back(8'h03);
      else if (r <= 9) begin
        fb.push_back(8'h02);
        fb.push_back(8'($urandom_range(0, 79)));
        repeat ($urandom_range(0, 3)) fb.push_back(8'($urandom));
        stop = 1'b1;
      end else if (r == 10) begin
        fb.push_back(8'($urandom_range(5, 255)));
        fb.push_back(8'h01);
        stop = 1'b1;
      end else begin
        rnd_draw();
        repeat ($urandom_range(1, 5)) void'(fb.pop_back());
        stop = 1'b1;
      end
    end
    tail_bits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
  endtask

  initial begin
    int         tb;
    logic [7:0] rx;
    logic [7:0] rest;

    cyc(3);
    chk_val("rst_empty", is_empty, 1'b1);
    chk_val("rst_full", is_full, 1'b0);
    chk_val("rst_miso", spi_miso, 1'b0);
    chk_val("rst_w_en", sprite_w_en, 1'b0);
    chk_val("rst_ovf", overflow_count, 8'h00);
    chk_val("rst_head", {sprite_id, sprite_x, sprite_y, sprite_scale}, 48'h0);
    chk_val("rst_sel", sprite_select, 6'd0);
    sys_reset_n = 1'b1;
    cyc(5);

    fb = {8'h01, 8'h07, 8'h00, 8'h64, 8'h00, 8'hC8, 8'h02};
    chk_val("d1_empty_before", is_empty, 1'b1);
    run_frame(0, 8'h00);
    chk_val("d1_head", {sprite_id, sprite_x, sprite_y, sprite_scale}, {8'd7, 16'd100, 16'd200, 8'd2});

    fb.delete();
    rnd_draw();
    rnd_draw();
    run_frame(0, 8'h00);

    fb = {8'h04, 8'h00};
    run_frame(0, 8'h00);
    chk_val("status_3_entries", act_rx[1], 8'h00);

    fb = {8'h03};
    run_frame(0, 8'h00);
    chk_val("flush_empty", is_empty, 1'b1);

    fb = {8'h02, 8'h05, 8'hAA, 8'hBB, 8'hCC};
    run_frame(0, 8'h00);
    chk_val("load_select", sprite_select, 6'd5);

    fb = {8'h02, 8'h40, 8'h11, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_frame(0, 8'h00);

    fb = {8'h01, 8'h07, 8'h00};
    run_frame(4, 8'h5A);
    fb.delete();
    rnd_draw();
    run_frame(0, 8'h00);

    do_deq(mq.size() + 1);
    fb.delete();
    repeat (17) rnd_draw();
    run_frame(0, 8'h00);
    chk_val("ovf_full", is_full, 1'b1);
    chk_val("ovf_count", overflow_count, 8'd1);

    for (int f = 0; f < 20; f++) begin
      do_deq(int'($urandom_range(0, 4)));
      rnd_frame(tb);
      run_frame(tb, 8'($urandom));
    end

    spi_cs = 1'b0;
    cyc(HALF);
    spi_bits(8'h02, 8, rx);
    spi_bits(8'h03, 8, rx);
    spi_bits(8'hAA, 8, rx);
    exp_wr.push_back({6'd3, 12'd0, 8'hAA});
    spi_bits(8'hBB, 3, rx);
    @(negedge sys_clock);
    #2 sys_reset_n = 1'b0;
    #1;
    chk_val("midrst_empty", is_empty, 1'b1);
    chk_val("midrst_ovf", overflow_count, 8'h00);
    chk_val("midrst_sel", sprite_select, 6'd0);
    chk_val("midrst_w_en", sprite_w_en, 1'b0);
    mq.delete();
    ovf_m = 0;
    cyc(2);
    sys_reset_n = 1'b1;
    rest = 8'hBB;
    rest = rest << 3;
    spi_bits(rest, 5, rx);
    spi_bits(8'hCC, 8, rx);
    spi_bits(8'hDD, 8, rx);
    cyc(HALF);
    spi_cs = 1'b1;
    cyc(2 * HALF);
    check_state();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    failures++;
    $display("FAIL watchdog got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
